// File: rtl/turn_sequencer_if.sv
// Shared screen-state type and the peer move link (tx/rx valid/ready).
// master = sequencer side, slave = peer side.
package turn_sequencer_pkg;
  typedef enum logic [1:0] {
    TITLE_SCREEN = 2'd0,
    CHESS_SCREEN = 2'd1,
    END_SCREEN   = 2'd2,
    MENU_SCREEN  = 2'd3
  } screen_state_t;
endpackage

// Ports:
//  rx_valid/rx_data/rx_ready : remote move into the sequencer
//  tx_valid/tx_data/tx_ready : local move out to the peer
interface turn_sequencer_if;
  logic        rx_valid;
  logic [11:0] rx_data;
  logic        rx_ready;
  logic        tx_valid;
  logic [11:0] tx_data;
  logic        tx_ready;

  modport master (
    input  rx_valid, rx_data, tx_ready,
    output rx_ready, tx_valid, tx_data
  );

  modport slave (
    output rx_valid, rx_data, tx_ready,
    input  rx_ready, tx_valid, tx_data
  );
endinterface

// File: rtl/turn_sequencer.sv
// Turn sequencer: owns the 8x8 board, commits local/remote moves.
// Ports: CLOCK_50, reset (sync, high), sys_state, player, new_game,
//  moved, move_packet, link (peer tx/rx), stable_board[x][y],
//  curr_player, move_count, move_reject, game_over, winner, link_error.
module turn_sequencer
  import turn_sequencer_pkg::*;
#(
  parameter int TX_TIMEOUT = 50_000_000,
  parameter int CNT_W      = 8
) (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  input  screen_state_t        sys_state,
  input  logic                 player,
  input  logic                 new_game,
  input  logic                 moved,
  input  logic [11:0]          move_packet,
  turn_sequencer_if.master     link,
  output logic [7:0][7:0][3:0] stable_board,
  output logic                 curr_player,
  output logic [CNT_W-1:0]     move_count,
  output logic                 move_reject,
  output logic                 game_over,
  output logic                 winner,
  output logic                 link_error
);

  localparam int TW = $clog2(TX_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_WAIT,
    S_CHECK,
    S_APPLY,
    S_TX,
    S_TOGGLE,
    S_HALT
  } state_t;

  state_t               state_q;
  logic [7:0][7:0][3:0] board_q;
  logic [11:0]          pkt_q;
  logic                 local_q;
  logic                 cur_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 rej_q;
  logic                 over_q;
  logic                 win_q;
  logic                 lerr_q;
  logic                 txv_q;
  logic [TW-1:0]        tmr_q;

  function automatic logic [3:0] back_rank(input int x);
    unique case (x)
      0, 7:    return 4'd3;
      1, 6:    return 4'd1;
      2, 5:    return 4'd2;
      3:       return 4'd4;
      default: return 4'd5;
    endcase
  endfunction

  function automatic logic [7:0][7:0][3:0] start_board();
    logic [7:0][7:0][3:0] b;
    for (int x = 0; x < 8; x++) begin
      for (int y = 0; y < 8; y++) begin
        b[x][y] = 4'hF;
      end
      b[x][0] = back_rank(x);
      b[x][1] = 4'd0;
      b[x][6] = 4'd6;
      b[x][7] = back_rank(x) + 4'd6;
    end
    return b;
  endfunction

  // Colour 1 owns codes 0-5, colour 0 owns 6-11.
  function automatic logic owns(input logic [3:0] code,
                                input logic       c);
    if (c) return code <= 4'd5;
    return (code >= 4'd6) && (code <= 4'd11);
  endfunction

  logic [2:0] sx, sy, dx, dy;
  logic [3:0] src_pc, dst_pc;
  logic       chess;
  logic       remote_turn;
  logic       bad_move;
  logic       tx_hs;

  assign sx          = pkt_q[11:9];
  assign sy          = pkt_q[8:6];
  assign dx          = pkt_q[5:3];
  assign dy          = pkt_q[2:0];
  assign src_pc      = board_q[sx][sy];
  assign dst_pc      = board_q[dx][dy];
  assign chess       = (sys_state == CHESS_SCREEN);
  assign remote_turn = (cur_q != player);
  assign tx_hs       = txv_q && link.tx_ready;

  assign bad_move = ({sx, sy} == {dx, dy})
                 || (src_pc == 4'hF)
                 || !owns(src_pc, cur_q)
                 || owns(dst_pc, cur_q);

  // Accept is combinational so the peer sees it in the offer cycle.
  assign link.rx_ready = !reset && !new_game && chess
                      && (state_q == S_WAIT) && remote_turn
                      && link.rx_valid;

  assign link.tx_valid = txv_q;
  assign link.tx_data  = pkt_q;
  assign stable_board  = board_q;
  assign curr_player   = cur_q;
  assign move_count    = cnt_q;
  assign move_reject   = rej_q;
  assign game_over     = over_q;
  assign winner        = win_q;
  assign link_error    = lerr_q;

  always_ff @(posedge CLOCK_50) begin
    if (reset || new_game) begin
      state_q <= S_WAIT;
      board_q <= start_board();
      pkt_q   <= '0;
      local_q <= 1'b0;
      cur_q   <= 1'b0;
      cnt_q   <= '0;
      rej_q   <= 1'b0;
      over_q  <= 1'b0;
      win_q   <= 1'b0;
      lerr_q  <= 1'b0;
      txv_q   <= 1'b0;
      tmr_q   <= '0;
    end else begin
      rej_q <= 1'b0;
      unique case (state_q)
        S_WAIT: begin
          if (chess) begin
            if (!remote_turn) begin
              if (moved) begin
                pkt_q   <= move_packet;
                local_q <= 1'b1;
                state_q <= S_CHECK;
              end
            end else if (link.rx_valid) begin
              pkt_q   <= link.rx_data;
              local_q <= 1'b0;
              state_q <= S_CHECK;
            end
          end
        end
        S_CHECK: begin
          if (chess) begin
            if (bad_move) begin
              rej_q   <= 1'b1;
              state_q <= S_WAIT;
            end else begin
              state_q <= S_APPLY;
            end
          end
        end
        S_APPLY: begin
          if (chess) begin
            board_q[dx][dy] <= src_pc;
            board_q[sx][sy] <= 4'hF;
            if (dst_pc == 4'd5 || dst_pc == 4'd11) begin
              over_q <= 1'b1;
              win_q  <= cur_q;
            end
            if (local_q) begin
              state_q <= S_TX;
              txv_q   <= 1'b1;
              tmr_q   <= '0;
            end else begin
              state_q <= S_TOGGLE;
            end
          end
        end
        // The peer link must drain even off the chess screen.
        S_TX: begin
          if (tx_hs) begin
            txv_q   <= 1'b0;
            state_q <= S_TOGGLE;
          end else if (tmr_q == TW'(TX_TIMEOUT - 1)) begin
            txv_q   <= 1'b0;
            lerr_q  <= 1'b1;
            state_q <= S_HALT;
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end
        S_TOGGLE: begin
          if (chess) begin
            cur_q <= ~cur_q;
            if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
            state_q <= over_q ? S_HALT : S_WAIT;
          end
        end
        S_HALT: begin
          state_q <= S_HALT;
        end
        default: begin
          state_q <= S_WAIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_turn_sequencer.sv
// Bench for turn_sequencer: random moves against a board model,
// tx packets and rejects checked by a scoreboard monitor.
module tb_turn_sequencer;
  import turn_sequencer_pkg::*;

  localparam int TO   = 16;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  screen_state_t        sys_state = CHESS_SCREEN;
  logic                 player = 1'b0;
  logic                 new_game = 1'b0;
  logic                 moved = 1'b0;
  logic [11:0]          move_packet = '0;
  logic [7:0][7:0][3:0] stable_board;
  logic                 curr_player;
  logic [CW-1:0]        move_count;
  logic                 move_reject, game_over, winner, link_error;

  turn_sequencer_if link();

  turn_sequencer #(.TX_TIMEOUT(TO), .CNT_W(CW)) dut (
    .CLOCK_50    (clk),
    .reset       (reset),
    .sys_state   (sys_state),
    .player      (player),
    .new_game    (new_game),
    .moved       (moved),
    .move_packet (move_packet),
    .link        (link.master),
    .stable_board(stable_board),
    .curr_player (curr_player),
    .move_count  (move_count),
    .move_reject (move_reject),
    .game_over   (game_over),
    .winner      (winner),
    .link_error  (link_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_tx;
    logic [11:0] data;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;
  bit   hold_ready = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: plain board array plus game bookkeeping.
  int mb[8][8];
  int back[8] = '{3, 1, 2, 4, 5, 2, 1, 3};
  bit mcurr, mover, mwin, mhalt, mlerr;
  int mcnt;

  function automatic void mreset();
    for (int x = 0; x < 8; x++) begin
      for (int y = 0; y < 8; y++) mb[x][y] = 15;
      mb[x][0] = back[x];
      mb[x][1] = 0;
      mb[x][6] = 6;
      mb[x][7] = back[x] + 6;
    end
    mcurr = 0; mcnt = 0; mover = 0;
    mwin = 0; mhalt = 0; mlerr = 0;
  endfunction

  function automatic bit owns(input int code, input bit c);
    if (c) return code >= 0 && code <= 5;
    return code >= 6 && code <= 11;
  endfunction

  function automatic logic [11:0] pk(input int sx, input int sy,
                                     input int dx, input int dy);
    return {3'(sx), 3'(sy), 3'(dx), 3'(dy)};
  endfunction

  function automatic bit mlegal(input logic [11:0] p);
    int sx = int'(p[11:9]);
    int sy = int'(p[8:6]);
    int dx = int'(p[5:3]);
    int dy = int'(p[2:0]);
    if (sx == dx && sy == dy) return 0;
    if (mb[sx][sy] == 15) return 0;
    if (!owns(mb[sx][sy], mcurr)) return 0;
    return !owns(mb[dx][dy], mcurr);
  endfunction

  // Returns true if a king was captured.
  function automatic bit mapply(input logic [11:0] p);
    int sx = int'(p[11:9]);
    int sy = int'(p[8:6]);
    int dx = int'(p[5:3]);
    int dy = int'(p[2:0]);
    int cap = mb[dx][dy];
    mb[dx][dy] = mb[sx][sy];
    mb[sx][sy] = 15;
    if (cap == 5 || cap == 11) begin
      mover = 1; mwin = mcurr; mhalt = 1;
      return 1;
    end
    return 0;
  endfunction

  function automatic logic [11:0] pick_move();
    int srcs[$];
    int s, dx, dy;
    if ($urandom_range(0, 9) < 3) return 12'($urandom);
    for (int i = 0; i < 64; i++)
      if (owns(mb[i / 8][i % 8], mcurr)) srcs.push_back(i);
    if (srcs.size() == 0) return 12'($urandom);
    s = srcs[$urandom_range(0, srcs.size() - 1)];
    for (int t = 0; t < 64; t++) begin
      dx = $urandom_range(0, 7);
      dy = $urandom_range(0, 7);
      if (!(dx == s / 8 && dy == s % 8) && !owns(mb[dx][dy], mcurr))
        return pk(s / 8, s % 8, dx, dy);
    end
    return 12'($urandom);
  endfunction

  function automatic logic [11:0] pick_legal();
    logic [11:0] p;
    for (int t = 0; t < 200; t++) begin
      p = pick_move();
      if (mlegal(p)) return p;
    end
    return p;
  endfunction

  task automatic check_state(input string tag);
    int bad = 0;
    for (int x = 0; x < 8; x++)
      for (int y = 0; y < 8; y++)
        if (stable_board[x][y] !== 4'(mb[x][y])) bad++;
    chk({tag, " board squares wrong"}, bad, 0);
    chk({tag, " curr_player"}, curr_player, mcurr);
    chk({tag, " move_count"}, move_count, mcnt);
    chk({tag, " game_over"}, game_over, mover);
    chk({tag, " winner"}, winner, mwin);
    chk({tag, " link_error"}, link_error, mlerr);
    chk({tag, " tx_valid idle"}, link.tx_valid, 0);
    chk({tag, " move_reject idle"}, move_reject, 0);
    chk({tag, " scoreboard pending"}, expq.size(), 0);
  endtask

  task automatic do_move(input logic [11:0] p);
    bit loc = (mcurr == player);
    bit acc = !mhalt;
    bit ok  = acc && mlegal(p);
    int n   = 0;
    if (acc && !ok) expq.push_back('{1'b0, 12'h000});
    if (ok && loc) expq.push_back('{1'b1, p});
    if (loc) begin
      moved = 1; move_packet = p;
      @(posedge clk); #1;
      moved = 0;
    end else begin
      link.rx_valid = 1; link.rx_data = p;
      @(negedge clk);
      chk("rx_ready on remote offer", link.rx_ready, acc);
      @(posedge clk); #1;
      link.rx_valid = 0;
    end
    if (ok) begin
      void'(mapply(p));
      mcurr = !mcurr;
      if (mcnt < CMAX) mcnt++;
      do begin
        @(negedge clk);
        n++;
      end while (curr_player !== mcurr && n < 200);
      chk("turn completes within budget", n < 200, 1);
    end else begin
      repeat (4) @(negedge clk);
    end
    @(posedge clk); #1;
    check_state("move");
  endtask

  // Inputs the sequencer must ignore in its current situation.
  task automatic noise(input bit off);
    bit use_moved = off ? (mcurr == player) : (mcurr != player);
    if (off) sys_state = TITLE_SCREEN;
    if (use_moved) begin
      moved = 1; move_packet = pick_legal();
      @(posedge clk); #1;
      moved = 0;
    end else begin
      link.rx_valid = 1; link.rx_data = pick_legal();
      @(negedge clk);
      chk("rx_ready when not accepting", link.rx_ready, 0);
      @(posedge clk); #1;
      link.rx_valid = 0;
    end
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
    sys_state = CHESS_SCREEN;
    check_state("ignored input");
  endtask

  task automatic do_new_game(input bit p);
    new_game = 1; moved = 1; player = p;
    move_packet = pk(4, 6, 4, 4);
    link.rx_valid = 1; link.rx_data = pk(4, 1, 4, 3);
    @(negedge clk);
    chk("rx_ready under new_game", link.rx_ready, 0);
    @(posedge clk); #1;
    new_game = 0; moved = 0; link.rx_valid = 0;
    mreset();
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    check_state("new_game");
  endtask

  task automatic do_timeout();
    logic [11:0] p = pick_legal();
    int n = 0;
    int k = 0;
    hold_ready = 1;
    moved = 1; move_packet = p;
    @(posedge clk); #1;
    moved = 0;
    void'(mapply(p));
    mlerr = 1; mhalt = 1;
    while (!link_error && k < 100) begin
      @(negedge clk);
      if (link.tx_valid) n++;
      k++;
    end
    chk("tx_valid cycles before link_error", n, TO);
    hold_ready = 0;
    @(posedge clk); #1;
    check_state("timeout");
  endtask

  // Peer readiness: random, but never low long enough to time out.
  initial begin
    int z = 0;
    link.tx_ready = 0;
    forever begin
      @(posedge clk); #1;
      if (hold_ready) begin
        link.tx_ready = 0;
      end else if (z >= 3 || $urandom_range(0, 3) != 0) begin
        link.tx_ready = 1; z = 0;
      end else begin
        link.tx_ready = 0; z++;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (link.tx_valid && link.tx_ready) begin
        chk("tx transfer was expected", expq.size() > 0, 1);
        if (expq.size() > 0) begin
          e = expq.pop_front();
          chk("event kind (tx)", 1, e.is_tx);
          chk("tx_data", link.tx_data, e.data);
        end
      end
      if (move_reject) begin
        chk("reject was expected", expq.size() > 0, 1);
        if (expq.size() > 0) begin
          e = expq.pop_front();
          chk("event kind (reject)", 0, e.is_tx);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    link.rx_valid = 0;
    link.rx_data  = '0;
    mreset();
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("reset rx_ready", link.rx_ready, 0);
    @(posedge clk); #1;
    check_state("reset");

    do_move(pk(4, 4, 4, 5));
    do_move(pk(4, 6, 4, 6));
    do_move(pk(4, 6, 4, 4));
    do_move(pk(4, 1, 4, 3));
    do_move(pk(3, 7, 4, 0));
    noise(0);
    do_move(pk(4, 3, 4, 4));
    noise(1);

    do_new_game(1);
    do_move(pick_legal());
    do_timeout();
    do_move(pick_legal());
    do_new_game(0);

    for (int i = 0; i < 400; i++) begin
      int r = $urandom_range(0, 19);
      if (r == 0 || (mhalt && r < 6))
        do_new_game(1'($urandom_range(0, 1)));
      else if (r == 1)
        noise(1'($urandom_range(0, 1)));
      else
        do_move(pick_move());
    end

    chk("scoreboard drained", expq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
